m1_inv_seq: RTL

- Sequential inverse of the cipher's 16-bit column mixing layer, used on the decryption datapath.
- Accepts a full multi-column state over a valid/ready handshake.
- Un-mixes one 16-bit column per clock through a combinational inverse-mix core.
- Presents the recovered state over a valid/ready output handshake.

---
 rtl/future_mix_pkg.sv | 31 +++
 rtl/m1_inv_col.sv | 11 +
 rtl/m1_inv_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/future_mix_pkg.sv
// rtl/future_mix_pkg.sv - shared column mix definitions for the encrypt and decrypt datapaths
package future_mix_pkg;

  localparam int COL_W = 16;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } m1_inv_state_t;

  function automatic logic [COL_W-1:0] fwd_mix_col(input logic [COL_W-1:0] n);
    logic [NIB_W-1:0] n0, n1, n2, n3;
    n0 = n[3:0];
    n1 = n[7:4];
    n2 = n[11:8];
    n3 = n[15:12];
    return {n2, n0 ^ n1, n0, n3 ^ n2};
  endfunction

  function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] c);
    logic [NIB_W-1:0] c0, c1, c2, c3;
    c0 = c[3:0];
    c1 = c[7:4];
    c2 = c[11:8];
    c3 = c[15:12];
    return {c0 ^ c3, c3, c2 ^ c1, c1};
  endfunction

endpackage

// File: rtl/m1_inv_col.sv
// rtl/m1_inv_col.sv - combinational inverse mix of one 16-bit column
module m1_inv_col
  import future_mix_pkg::*;
(
  input  logic [COL_W-1:0] col,
  output logic [COL_W-1:0] mixed
);

  assign mixed = inv_mix_col(col);

endmodule

// File: rtl/m1_inv_seq.sv
// rtl/m1_inv_seq.sv - column-serial inverse mix; optional self-check via M1_INV_SELFCHECK_EN
module m1_inv_seq
  import future_mix_pkg::*;
#(
  parameter int NUM_COLS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COL_W*NUM_COLS-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COL_W*NUM_COLS-1:0] out_data,
`ifdef M1_INV_SELFCHECK_EN
  output logic                      busy,
  output logic                      chk_err
`else
  output logic                      busy
`endif
);

  localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

  m1_inv_state_t                 state;
  logic [IDX_W-1:0]              col_idx;
  logic [COL_W*NUM_COLS-1:0]     work;
  logic [COL_W-1:0]              cur_col;
  logic [COL_W-1:0]              inv_col;

  assign cur_col  = work[col_idx*COL_W +: COL_W];
  assign out_data = work;

  m1_inv_col u_col (
    .col   (cur_col),
    .mixed (inv_col)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col_idx   <= '0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            col_idx  <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          work[col_idx*COL_W +: COL_W] <= inv_col;
          // Exit on the terminal count so col_idx never needs to wrap.
          if (col_idx == LAST_IDX) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            col_idx <= col_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef M1_INV_SELFCHECK_EN
  // Compare against a copy of the captured state, so corruption of work is caught.
  logic [COL_W*NUM_COLS-1:0] orig;
  logic [COL_W-1:0]          orig_col;

  assign orig_col = orig[col_idx*COL_W +: COL_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orig    <= '0;
      chk_err <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      orig    <= in_data;
      chk_err <= 1'b0;
    end else if (state == RUN && fwd_mix_col(inv_col) != orig_col) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule
